// File: rtl/vector_store_unit.sv
// Vector store unit: serialises a captured vector of up to 16 words into
// consecutive 32-bit data-memory writes over a valid/ready port.
module vector_store_unit #(
  parameter int WORD_W = 32,
  parameter int VEC_W  = 512,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [VEC_W-1:0]  vdata,
  input  logic [1:0]        VL,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        last_q, last_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  assign accept = we_q & mem_ready;

  // The vector register shifts down one word per accepted beat, so the next
  // word to write is always at its bottom and mem_wd is loaded from state only.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        we_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          vec_d   = vdata >> WORD_W;
          wd_d    = vdata[WORD_W-1:0];
          addr_d  = base_addr & ~32'd3;
          idx_d   = 4'd0;
          case (VL)
            2'b00:   last_d = 4'd3;
            2'b01:   last_d = 4'd7;
            default: last_d = 4'd15;
          endcase
          err_d   = (VL == 2'b11);
          we_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = WRITE;
        end
      end

      WRITE: begin
        err_d = start;
        if (accept) begin
          if (idx_q == last_q) begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 4'd1;
            addr_d = addr_q + 32'(STRIDE);
            wd_d   = vec_q[WORD_W-1:0];
            vec_d  = vec_q >> WORD_W;
          end
        end
      end

      DONE: begin
        err_d   = start;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        we_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_wd   = wd_q;
  assign mem_we   = we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed self-checking bench for vector_store_unit with hand-computed
// addresses, data words and handshake timing.
module tb_vector_store_unit;

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  base_addr;
  logic [511:0] vdata;
  logic [1:0]   VL;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wd;
  logic         mem_we;
  logic         mem_ready;
  logic         busy;
  logic         done;
  logic         err;

  int compareCount;
  int mismatchCount;

  vector_store_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .vdata     (vdata),
    .VL        (VL),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  // Issue a start with word i = wordBase + i, then scramble the inputs so
  // any late sampling of vdata/base_addr/VL would show up in the beats.
  task automatic applyStimulus(input logic [1:0] vl, input logic [31:0] base,
                               input logic [31:0] wordBase);
    for (int i = 0; i < 16; i++) vdata[32*i +: 32] = wordBase + i;
    VL        = vl;
    base_addr = base;
    start     = 1'b1;
    stepCycle();
    start     = 1'b0;
    vdata     = '0;
    base_addr = 32'hDEADBEE0;
    VL        = 2'b00;
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] addr,
                           input logic [31:0] wd);
    checkOutput($sformatf("%s_we", tag), {31'd0, mem_we}, 32'd1);
    checkOutput($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1);
    checkOutput($sformatf("%s_done", tag), {31'd0, done}, 32'd0);
    checkOutput($sformatf("%s_addr", tag), mem_addr, addr);
    checkOutput($sformatf("%s_wd", tag), mem_wd, wd);
  endtask

  task automatic checkDone(input string tag);
    checkOutput($sformatf("%s_done", tag), {31'd0, done}, 32'd1);
    checkOutput($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1);
    checkOutput($sformatf("%s_we", tag), {31'd0, mem_we}, 32'd0);
    stepCycle();
    checkOutput($sformatf("%s_idle_busy", tag), {31'd0, busy}, 32'd0);
    checkOutput($sformatf("%s_idle_done", tag), {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [6:0]  readyPat;
    logic [31:0] wrapAddr [4];
    int          acc;

    compareCount  = 0;
    mismatchCount = 0;
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    vdata     = '0;
    VL        = 2'b00;
    mem_ready = 1'b1;

    #12;
    checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_wd", mem_wd, 32'd0);
    reset = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("idle_ready_we", {31'd0, mem_we}, 32'd0);

    // Full 16-word vector into an always-ready memory
    applyStimulus(2'b10, 32'h0000_0100, 32'hA000_0000);
    checkOutput("full_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      checkBeat($sformatf("full%0d", i), 32'h100 + 4 * i, 32'hA000_0000 + i);
      stepCycle();
    end
    checkDone("full");

    // Backpressure: each word must hold until accepted
    readyPat = 7'b1110100;
    applyStimulus(2'b00, 32'h0000_0200, 32'hB000_0000);
    acc = 0;
    for (int k = 0; k < 7; k++) begin
      mem_ready = readyPat[k];
      checkBeat($sformatf("bp%0d", k), 32'h200 + 4 * acc, 32'hB000_0000 + acc);
      stepCycle();
      if (readyPat[k]) acc++;
    end
    mem_ready = 1'b1;
    checkDone("bp");

    // Misaligned base wrapping through address zero
    wrapAddr[0] = 32'hFFFF_FFF4;
    wrapAddr[1] = 32'hFFFF_FFF8;
    wrapAddr[2] = 32'hFFFF_FFFC;
    wrapAddr[3] = 32'h0000_0000;
    applyStimulus(2'b00, 32'hFFFF_FFF7, 32'hC000_0000);
    for (int i = 0; i < 4; i++) begin
      checkBeat($sformatf("wrap%0d", i), wrapAddr[i], 32'hC000_0000 + i);
      stepCycle();
    end
    checkDone("wrap");

    // Reserved VL code: error pulse, then a full 16-word transfer
    applyStimulus(2'b11, 32'h0000_0400, 32'hD000_0000);
    checkOutput("rsv_err1", {31'd0, err}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkBeat($sformatf("rsv%0d", i), 32'h400 + 4 * i, 32'hD000_0000 + i);
      if (i == 1) checkOutput("rsv_err2", {31'd0, err}, 32'd0);
      stepCycle();
    end
    checkDone("rsv");

    // Start during beat 3 of an 8-word transfer is dropped with an error
    applyStimulus(2'b01, 32'h0000_0500, 32'hE000_0000);
    for (int i = 0; i < 8; i++) begin
      checkBeat($sformatf("drop%0d", i), 32'h500 + 4 * i, 32'hE000_0000 + i);
      if (i == 3) checkOutput("drop_err", {31'd0, err}, 32'd1);
      if (i == 4) checkOutput("drop_err_end", {31'd0, err}, 32'd0);
      if (i == 2) begin
        for (int j = 0; j < 16; j++) vdata[32*j +: 32] = 32'hDEAD_0000 + j;
        base_addr = 32'h0000_0900;
        VL        = 2'b10;
        start     = 1'b1;
        stepCycle();
        start     = 1'b0;
      end else begin
        stepCycle();
      end
    end
    checkDone("drop");
    stepCycle();
    checkOutput("drop_no_second_we", {31'd0, mem_we}, 32'd0);
    checkOutput("drop_no_second_busy", {31'd0, busy}, 32'd0);

    // Reset asserted during beat 5 abandons the transfer immediately
    applyStimulus(2'b10, 32'h0000_0600, 32'hF000_0000);
    for (int i = 0; i < 4; i++) begin
      checkBeat($sformatf("mid%0d", i), 32'h600 + 4 * i, 32'hF000_0000 + i);
      stepCycle();
    end
    checkBeat("mid4", 32'h610, 32'hF000_0004);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    stepCycle();
    stepCycle();
    reset = 1'b1;
    stepCycle();
    checkOutput("postrst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("postrst_busy", {31'd0, busy}, 32'd0);
    applyStimulus(2'b00, 32'h0000_0700, 32'h7700_0000);
    for (int i = 0; i < 4; i++) begin
      checkBeat($sformatf("post%0d", i), 32'h700 + 4 * i, 32'h7700_0000 + i);
      stepCycle();
    end
    checkDone("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
